logic_op_issuer: RTL and testbench

- Initiator-side sequencer for the team's 2-bit-select combinational logic unit (AND/OR/XOR/NOT-a).
- Accepts operation requests on a valid/ready port and buffers them in an in-order FIFO.
- Drives operands and select to the external logic unit, registers its result, and returns it on a valid/ready response port.
- Sits between a command producer and the logic unit, decoupling both sides with backpressure.

---
 rtl/logic_op_issuer.sv | 83 ++++++++
 tb/tb_logic_op_issuer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_issuer.sv
// logic_op_issuer: FIFO-buffered request sequencer for the 2-bit-select logic unit.
// Define LOGIC_OP_CHECK_EN to add the err_sticky result checker.
module logic_op_issuer #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_W-1:0]       req_a,
    input  logic [DATA_W-1:0]       req_b,
    input  logic [1:0]              req_sel,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [1:0]              alu_sel,
    input  logic [DATA_W-1:0]       alu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_result,
    output logic [1:0]              rsp_sel,
`ifdef LOGIC_OP_CHECK_EN
    output logic                    err_sticky,
`endif
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic [1:0]        mem_sel [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              push, pop, nonempty;
    always_comb begin
        nonempty  = count != '0;
        req_ready = count != FULL;
        push      = req_valid & req_ready;
        pop       = nonempty & (!rsp_valid | rsp_ready);
        alu_a     = nonempty ? mem_a[rd_ptr] : '0;
        alu_b     = nonempty ? mem_b[rd_ptr] : '0;
        alu_sel   = nonempty ? mem_sel[rd_ptr] : '0;
    end
    // Storage carries no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= req_a;
            mem_b[wr_ptr]   <= req_b;
            mem_sel[wr_ptr] <= req_sel;
        end
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_sel    <= '0;
        end else begin
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                rsp_result <= alu_result;
                rsp_sel    <= alu_sel;
                rsp_valid  <= 1'b1;
            end else if (rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end
`ifdef LOGIC_OP_CHECK_EN
    logic [DATA_W-1:0] golden;
    always_comb
        golden = alu_sel == 2'b00 ? alu_a & alu_b :
                 alu_sel == 2'b01 ? alu_a | alu_b :
                 alu_sel == 2'b10 ? alu_a ^ alu_b : ~alu_a;
    always_ff @(posedge clk) begin
        if (!resetn) err_sticky <= 1'b0;
        else if (pop && alu_result != golden) err_sticky <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_logic_op_issuer.sv
// tb_logic_op_issuer: queue-based reference model with per-cycle compare plus directed literal checks.
module tb_logic_op_issuer;
    localparam int DEPTH = 4;
    logic clk = 0, resetn = 0, req_valid = 0, rsp_ready = 0, inject = 0;
    logic [3:0] req_a = 0, req_b = 0, alu_a, alu_b, alu_result, rsp_result;
    logic [1:0] req_sel = 0, alu_sel, rsp_sel;
    logic req_ready, rsp_valid;
    logic [2:0] count;
`ifdef LOGIC_OP_CHECK_EN
    logic err_sticky;
    bit merr;
`endif
    int checks = 0, errors = 0;
    bit run = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] f(logic [3:0] a, logic [3:0] b, logic [1:0] s);
        case (s)
            2'd0: return a & b;
            2'd1: return a | b;
            2'd2: return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign alu_result = inject ? 4'hF : f(alu_a, alu_b, alu_sel);

    logic_op_issuer #(.DATA_W(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_sel(rsp_sel),
`ifdef LOGIC_OP_CHECK_EN
        .err_sticky(err_sticky),
`endif
        .count(count)
    );

    // Model: pending ops as a queue, response slot as a flag plus value.
    typedef struct packed {logic [3:0] a, b; logic [1:0] s;} op_t;
    op_t q[$];
    bit mv, mpop, mpush;
    logic [3:0] mr = 0;
    logic [1:0] ms = 0;
    always @(posedge clk) begin
        if (!resetn) begin
            q.delete(); mv = 0; mr = 0; ms = 0;
`ifdef LOGIC_OP_CHECK_EN
            merr = 0;
`endif
        end else begin
            mpop = q.size() > 0 && (!mv || rsp_ready);
            mpush = req_valid && q.size() < DEPTH;
            if (mpop) begin
`ifdef LOGIC_OP_CHECK_EN
                if (inject && f(q[0].a, q[0].b, q[0].s) != 4'hF) merr = 1;
`endif
                mr = inject ? 4'hF : f(q[0].a, q[0].b, q[0].s);
                ms = q[0].s;
                mv = 1;
                void'(q.pop_front());
            end else if (mv && rsp_ready) mv = 0;
            if (mpush) q.push_back({req_a, req_b, req_sel});
        end
    end

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
        end
    endtask

    always @(negedge clk) if (run) begin
        chk("count", 32'(count), q.size());
        chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
        chk("rsp_valid", 32'(rsp_valid), 32'(mv));
        chk("rsp_result", 32'(rsp_result), 32'(mr));
        chk("rsp_sel", 32'(rsp_sel), 32'(ms));
        chk("alu_a", 32'(alu_a), q.size() > 0 ? 32'(q[0].a) : 0);
        chk("alu_b", 32'(alu_b), q.size() > 0 ? 32'(q[0].b) : 0);
        chk("alu_sel", 32'(alu_sel), q.size() > 0 ? 32'(q[0].s) : 0);
`ifdef LOGIC_OP_CHECK_EN
        chk("err_sticky", 32'(err_sticky), 32'(merr));
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [3:0] a, logic [3:0] b, logic [1:0] s);
        req_valid = v; req_a = a; req_b = b; req_sel = s;
    endtask

    initial begin
        logic [3:0] exp_s [4];
        exp_s = '{4'h8, 4'hE, 4'h6, 4'h3};
        cyc(); cyc();
        run = 1;
        chk("reset_count", 32'(count), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        resetn = 1;
        rsp_ready = 1;
        // single op
        drive(1, 4'hC, 4'hA, 2'b00);
        cyc();
        chk("single_count_t1", 32'(count), 1);
        chk("single_valid_t1", 32'(rsp_valid), 0);
        drive(0, 0, 0, 0);
        cyc();
        chk("single_valid_t2", 32'(rsp_valid), 1);
        chk("single_result", 32'(rsp_result), 32'h8);
        chk("single_count_t2", 32'(count), 0);
        // streaming
        for (int i = 0; i < 8; i++) begin
            drive(1, 4'hC, 4'hA, 2'(i));
            chk("stream_req_ready", 32'(req_ready), 1);
            if (i >= 2) chk("stream_result", 32'(rsp_result), 32'(exp_s[(i-2)%4]));
            cyc();
        end
        drive(0, 0, 0, 0);
        chk("stream_result_6", 32'(rsp_result), 32'h6);
        cyc();
        chk("stream_result_7", 32'(rsp_result), 32'h3);
        cyc();
        chk("stream_drained", 32'(rsp_valid), 0);
        // backpressure then full
        rsp_ready = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'(3*i+1), 4'h7, 2'(i));
            cyc();
        end
        drive(1, 4'hF, 4'hF, 2'd3);
        chk("bp_count", 32'(count), 4);
        chk("bp_req_ready", 32'(req_ready), 0);
        chk("bp_valid", 32'(rsp_valid), 1);
        chk("bp_result", 32'(rsp_result), 32'h1);
        cyc();
        chk("bp_hold_count", 32'(count), 4);
        chk("bp_hold_result", 32'(rsp_result), 32'h1);
        rsp_ready = 1;
        cyc();
        chk("full_pop_count", 32'(count), 3);
        chk("full_pop_ready", 32'(req_ready), 1);
        chk("full_pop_result", 32'(rsp_result), 32'h7);
        cyc();
        chk("pushpop_count", 32'(count), 3);
        chk("pushpop_result", 32'(rsp_result), 32'h0);
        cyc();
        drive(0, 0, 0, 0);
        repeat (8) cyc();
        chk("drain_count", 32'(count), 0);
        chk("drain_valid", 32'(rsp_valid), 0);
        // reset mid-operation
        rsp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'(i+2), 4'h3, 2'd1);
            cyc();
        end
        drive(0, 0, 0, 0);
        chk("mid_count", 32'(count), 3);
        chk("mid_valid", 32'(rsp_valid), 1);
        resetn = 0;
        cyc();
        resetn = 1;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_result", 32'(rsp_result), 0);
        rsp_ready = 1;
        repeat (4) cyc();
        chk("rst_no_stale", 32'(rsp_valid), 0);
        // forced bad result
        inject = 1;
        drive(1, 4'h0, 4'h0, 2'd0);
        cyc();
        drive(0, 0, 0, 0);
        cyc();
        chk("inject_result", 32'(rsp_result), 32'hF);
`ifdef LOGIC_OP_CHECK_EN
        chk("err_set", 32'(err_sticky), 1);
`endif
        inject = 0;
        drive(1, 4'h5, 4'h3, 2'd2);
        cyc();
        drive(0, 0, 0, 0);
        repeat (2) cyc();
        chk("post_inject_result", 32'(rsp_result), 32'h6);
`ifdef LOGIC_OP_CHECK_EN
        chk("err_stays", 32'(err_sticky), 1);
`endif
        resetn = 0;
        cyc();
        resetn = 1;
`ifdef LOGIC_OP_CHECK_EN
        chk("err_cleared", 32'(err_sticky), 0);
`endif
        cyc();
        run = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
